// File: rtl/uart_echo_responder_if.sv
// uart_echo_responder_if: handshake bundle between the uart core and the echo responder.
// Latency: none; wires only.
// Backpressure: none here; pacing comes from tx_done_tick on the transmit side.
// Signals: rx_done_tick/rx_dout (receiver word strobe and data), tx_done_tick (stop bit done),
//          tx_start/tx_din (transmit request and word).
// master = uart core side, slave = echo responder side.
interface uart_echo_responder_if #(
  parameter int DBIT = 8
);
  logic            rx_done_tick;
  logic [DBIT-1:0] rx_dout;
  logic            tx_done_tick;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;

  modport master (
    output rx_done_tick,
    output rx_dout,
    output tx_done_tick,
    input  tx_start,
    input  tx_din
  );

  modport slave (
    input  rx_done_tick,
    input  rx_dout,
    input  tx_done_tick,
    output tx_start,
    output tx_din
  );
endinterface

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: queues every received UART word and echoes it back in order through the transmitter.
// Latency: rx_done_tick in cycle N gives tx_start in N+2 from idle; tx_done_tick in M gives the next tx_start in M+2.
// Backpressure: the transmitter paces pops via tx_done_tick; a word arriving while the FIFO is full is dropped and sets overflow.
// Ports: clk; reset_n (async, active-low); uart (slave modport: rx_done_tick/rx_dout in, tx_done_tick in,
//        tx_start/tx_din out, both registered); ovf_clr clears overflow; busy is high in START/WAIT;
//        fifo_count is the number of queued words (0..2^FIFO_AW); overflow is the sticky drop flag.
// Option macro UART_ECHO_UPCASE_EN: when defined and DBIT == 8, ASCII a-z is folded to A-Z at pop time.
module uart_echo_responder #(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_echo_responder_if.slave uart,
  input  logic                 ovf_clr,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [DBIT-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               full;
  logic               push;
  logic               pop;

  // Word transform applied on the way out of the FIFO.
  function automatic logic [DBIT-1:0] echo_word(input logic [DBIT-1:0] w);
    logic [DBIT-1:0] r;
    r = w;
`ifdef UART_ECHO_UPCASE_EN
    if (DBIT == 8) begin
      if (w >= DBIT'(8'h61) && w <= DBIT'(8'h7A)) begin
        r[5] = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  // Full is judged on the pre-edge count, so a push while full is dropped
  // even if the FSM pops in the same cycle.
  assign full = (fifo_count == FULL_COUNT);
  assign push = uart.rx_done_tick && !full;
  assign pop  = (state == IDLE) && (fifo_count != '0);

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= uart.rx_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (uart.rx_done_tick && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // tx_start and busy are registered alongside the state so they line up
  // with START and START/WAIT respectively.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      uart.tx_start <= 1'b0;
      uart.tx_din   <= '0;
      busy          <= 1'b0;
    end else begin
      uart.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            uart.tx_din   <= echo_word(mem[rd_ptr]);
            uart.tx_start <= 1'b1;
            busy          <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (uart.tx_done_tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed bench for uart_echo_responder with a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a; the bench plays both the receiver and the transmitter.
module tb_uart_echo_responder;

  localparam int DBIT    = 8;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;

`ifdef UART_ECHO_UPCASE_EN
  localparam logic [7:0] LOWER_A_ECHO = 8'h41;
`else
  localparam logic [7:0] LOWER_A_ECHO = 8'h61;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               ovf_clr;
  logic               busy;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;

  uart_echo_responder_if #(.DBIT(DBIT)) u_if ();

  uart_echo_responder #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart       (u_if),
    .ovf_clr    (ovf_clr),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] w);
`ifdef UART_ECHO_UPCASE_EN
    if (w >= 8'h61 && w <= 8'h7A) return w & 8'hDF;
`endif
    return w;
  endfunction

  // Reference model: a word queue plus "a word is out with the transmitter".
  // A queued word is handed out whenever nothing is out; the request is
  // visible the cycle after hand-out; the word is released by tx_done once
  // that request cycle has passed.
  logic [7:0] m_q[$];
  logic [7:0] exp_echo[$];
  logic [7:0] seen_q[$];
  bit         m_out   = 1'b0;
  bit         m_req   = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [7:0] m_din   = 8'h00;
  bit         m_full;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      exp_echo.delete();
      m_out = 1'b0;
      m_req = 1'b0;
      m_ovf = 1'b0;
      m_din = 8'h00;
    end else begin
      m_full = (m_q.size() == DEPTH);
      if (!m_out && m_q.size() != 0) begin
        m_din = xf(m_q.pop_front());
        m_out = 1'b1;
        m_req = 1'b1;
      end else if (m_req) begin
        m_req = 1'b0;
      end else if (m_out && u_if.tx_done_tick) begin
        m_out = 1'b0;
      end
      if (u_if.rx_done_tick && !m_full) begin
        m_q.push_back(u_if.rx_dout);
        exp_echo.push_back(xf(u_if.rx_dout));
      end
      if (u_if.rx_done_tick && m_full) m_ovf = 1'b1;
      else if (ovf_clr)                m_ovf = 1'b0;
    end
  end

  // Per-cycle compare against the model, plus in-order echo scoreboard.
  always @(negedge clk) begin
    chk("tx_start", u_if.tx_start, m_req);
    chk("tx_din", u_if.tx_din, m_din);
    chk("busy", busy, m_out);
    chk("fifo_count", fifo_count, m_q.size());
    chk("overflow", overflow, m_ovf);
    if (u_if.tx_start === 1'b1) begin
      n_starts++;
      seen_q.push_back(u_if.tx_din);
      if (exp_echo.size() != 0) begin
        chk("echo_order", u_if.tx_din, exp_echo.pop_front());
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL echo_extra: got tx_start with 0x%0h, expected no pending word", u_if.tx_din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    u_if.rx_done_tick = 1'b1;
    u_if.rx_dout      = w;
    tick();
    u_if.rx_done_tick = 1'b0;
  endtask

  task automatic done_pulse();
    u_if.tx_done_tick = 1'b1;
    tick();
    u_if.tx_done_tick = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      done_pulse();
      repeat (4) tick();
    end
  endtask

  logic [7:0] burst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int mark;

  initial begin
    reset_n           = 1'b0;
    ovf_clr           = 1'b0;
    u_if.rx_done_tick = 1'b0;
    u_if.rx_dout      = '0;
    u_if.tx_done_tick = 1'b0;
    repeat (3) tick();
    chk("rst_tx_start", u_if.tx_start, 0);
    chk("rst_tx_din", u_if.tx_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single word: tx_start two cycles after rx_done_tick.
    push_word(8'hA5);
    @(negedge clk);
    chk("single_cnt_n1", fifo_count, 1);
    chk("single_start_n1", u_if.tx_start, 0);
    tick();
    @(negedge clk);
    chk("single_start_n2", u_if.tx_start, 1);
    chk("single_din_n2", u_if.tx_din, 8'hA5);
    chk("single_busy_n2", busy, 1);
    repeat (3) tick();
    done_pulse();
    @(negedge clk);
    chk("single_busy_after_done", busy, 0);
    chk("single_cnt_after", fifo_count, 0);
    repeat (3) tick();

    // Burst while the transmitter is stalled, then paced drain.
    for (int i = 0; i < 4; i++) push_word(burst[i]);
    @(negedge clk);
    chk("burst_cnt_peak", fifo_count, 3);
    chk("burst_din_first", u_if.tx_din, 8'h11);
    for (int k = 0; k < 4; k++) begin
      repeat (97) tick();
      done_pulse();
      @(negedge clk);
      chk("burst_start_m1", u_if.tx_start, 0);
      tick();
      @(negedge clk);
      if (k < 3) begin
        chk("burst_start_m2", u_if.tx_start, 1);
        chk("burst_din_m2", u_if.tx_din, burst[k+1]);
      end else begin
        chk("burst_idle_end", busy, 0);
      end
    end
    repeat (3) tick();

    // Overflow: sixth word dropped.
    mark = seen_q.size();
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    @(negedge clk);
    chk("ovf_cnt_full", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_din", u_if.tx_din, 8'h01);
    repeat (20) tick();
    chk("ovf_sticky", overflow, 1);
    drain(5);
    chk("ovf_echo_len", seen_q.size() - mark, 5);
    for (int i = 0; i < 5; i++) chk("ovf_echo_word", seen_q[mark+i], 8'(i + 1));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    repeat (3) tick();

    // Simultaneous push and pop with two words queued.
    mark = seen_q.size();
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    @(negedge clk);
    chk("sim_cnt_before", fifo_count, 2);
    done_pulse();
    push_word(8'h7E);
    @(negedge clk);
    chk("sim_cnt_kept", fifo_count, 2);
    chk("sim_start", u_if.tx_start, 1);
    chk("sim_din", u_if.tx_din, 8'h32);
    repeat (3) tick();
    drain(3);
    chk("sim_echo_len", seen_q.size() - mark, 4);
    chk("sim_echo_last", seen_q[mark+3], 8'h7E);

    // Reset while in WAIT with two words queued.
    push_word(8'h51);
    push_word(8'h52);
    push_word(8'h53);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_tx_start", u_if.tx_start, 0);
    chk("mrst_tx_din", u_if.tx_din, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fifo_count", fifo_count, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    mark = n_starts;
    repeat (20) tick();
    chk("mrst_no_start", n_starts - mark, 0);
    push_word(8'h5A);
    tick();
    @(negedge clk);
    chk("mrst_new_start", u_if.tx_start, 1);
    chk("mrst_new_din", u_if.tx_din, 8'h5A);
    repeat (2) tick();
    drain(1);

    // Case folding option (or bit-exact echo when disabled).
    mark = seen_q.size();
    push_word(8'h61);
    push_word(8'h5B);
    repeat (3) tick();
    drain(2);
    chk("case_first", seen_q[mark], LOWER_A_ECHO);
    chk("case_second", seen_q[mark+1], 8'h5B);

    repeat (5) tick();
    chk("echo_drained", exp_echo.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
